// File: rtl/stim_pair_sequencer.sv
// Purpose: drives (first, second) value pairs onto the DUT input bus, with begin/end markers and a pair index.
// Latency: first value appears 1 cycle after start; each pair takes 2*PHASE_CYCLES cycles.
// Backpressure: hold freezes every register and suppresses pulses; a postponed pulse fires on the first released edge.
module stim_pair_sequencer #(
    parameter int          IN_SIZE      = 8,
    parameter int          SIM          = 16,
    parameter int          PHASE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED    = 32'hACE12468,
    parameter int          CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode_full,
    input  logic               hold,
    output logic [IN_SIZE-1:0] in_data,
    output logic               sim_begin,
    output logic               sim_end,
    output logic [CNT_W-1:0]   sim_idx,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (SIM > 1) ? $clog2(SIM) : 1;
    localparam int PC_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SIM - 1);
    localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PHASE_CYCLES - 1);
    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
    localparam logic [31:0]      SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0]      LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic               mode_q, mode_d;
    logic [IN_SIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               begin_q, begin_d;
    logic               end_q, end_d;

    logic [31:0]        lfsr_nx;
    logic [IN_SIZE-1:0] rnd_val;
    logic [IDX_W-1:0]   i_inc;
    logic [IDX_W-1:0]   first_src;

    // Full-mode values are the loop indices taken modulo 2^IN_SIZE.
    function automatic logic [IN_SIZE-1:0] idx_val(input logic [IDX_W-1:0] v);
        return IN_SIZE'(v);
    endfunction

    // One Galois step; only ever applied once per edge because at most one value loads per edge.
    always_comb begin
        lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        rnd_val = lfsr_nx[IN_SIZE-1:0];
        i_inc   = i_q + IDX_W'(1);
        // Next pair's first value: same row while j has room, otherwise the next row.
        first_src = (j_q != IDX_LAST) ? i_q : i_inc;
    end

    // Next-state and output computation; hold leaves every default in place.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        pc_d    = pc_q;
        lfsr_d  = lfsr_q;
        mode_d  = mode_q;
        data_d  = data_q;
        idx_d   = idx_q;
        begin_d = 1'b0;
        end_d   = 1'b0;
        if (!hold) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_d  = mode_full;
                        i_d     = '0;
                        j_d     = '0;
                        idx_d   = '0;
                        pc_d    = '0;
                        state_d = S_FIRST;
                        if (mode_full) begin
                            data_d = '0;
                        end else begin
                            data_d = rnd_val;
                            lfsr_d = lfsr_nx;
                        end
                    end
                end
                S_FIRST: begin
                    if (pc_q == PC_LAST) begin
                        state_d = S_SECOND;
                        pc_d    = '0;
                        begin_d = 1'b1;
                        if (mode_q) begin
                            data_d = idx_val(j_q);
                        end else begin
                            data_d = rnd_val;
                            lfsr_d = lfsr_nx;
                        end
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                S_SECOND: begin
                    if (pc_q == PC_LAST) begin
                        end_d = 1'b1;
                        idx_d = idx_q + CNT_W'(1);
                        pc_d  = '0;
                        if (j_q == IDX_LAST && i_q == IDX_LAST) begin
                            // Last pair: in_data keeps its final value.
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FIRST;
                            if (j_q != IDX_LAST) begin
                                j_d = j_q + IDX_W'(1);
                            end else begin
                                j_d = '0;
                                i_d = i_inc;
                            end
                            if (mode_q) begin
                                data_d = idx_val(first_src);
                            end else begin
                                data_d = rnd_val;
                                lfsr_d = lfsr_nx;
                            end
                        end
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset that overrides start and hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            pc_q    <= '0;
            lfsr_q  <= SEED_EFF;
            mode_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            begin_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pc_q    <= pc_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            begin_q <= begin_d;
            end_q   <= end_d;
        end
    end

    assign in_data   = data_q;
    assign sim_begin = begin_q;
    assign sim_end   = end_q;
    assign sim_idx   = idx_q;
    assign busy      = (state_q == S_FIRST) || (state_q == S_SECOND);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_stim_pair_sequencer.sv
// Purpose: self-checking bench for stim_pair_sequencer (IN_SIZE=2, SIM=5, PHASE_CYCLES=2, CNT_W=4).
// Latency: the model predicts outputs after every edge; they are compared on the following falling edge.
// Backpressure: hold is exercised mid-pair; the model postpones the pending transition the same number of edges.
module tb_stim_pair_sequencer;

    localparam int          IN_SIZE = 2;
    localparam int          SIM     = 5;
    localparam int          PC      = 2;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] SEED    = 32'hACE12468;
    localparam int          MASK    = (1 << IN_SIZE) - 1;
    localparam int          TOTAL   = SIM * SIM * 2 * PC;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               mode_full;
    logic               hold;
    logic [IN_SIZE-1:0] in_data;
    logic               sim_begin;
    logic               sim_end;
    logic [CNT_W-1:0]   sim_idx;
    logic               busy;
    logic               done;

    stim_pair_sequencer #(
        .IN_SIZE      (IN_SIZE),
        .SIM          (SIM),
        .PHASE_CYCLES (PC),
        .LFSR_SEED    (SEED),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode_full (mode_full),
        .hold      (hold),
        .in_data   (in_data),
        .sim_begin (sim_begin),
        .sim_end   (sim_end),
        .sim_idx   (sim_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is described only by how many un-held edges have passed since the start edge (m_t):
    // pair p = m_t / (2*PC); the second value of pair p loads at offset PC inside the pair.
    function automatic logic [31:0] lstep(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    function automatic logic [IN_SIZE-1:0] full_val(input int p, input bit second);
        int v;
        v = second ? (p % SIM) : (p / SIM);
        return IN_SIZE'(v & MASK);
    endfunction

    bit                 m_run;
    bit                 m_mode;
    int                 m_t;
    logic [31:0]        m_lfsr;
    logic [IN_SIZE-1:0] e_data;
    logic               e_begin;
    logic               e_end;
    logic [CNT_W-1:0]   e_idx;
    logic               e_busy;
    logic               e_done;

    always @(posedge clk) begin
        e_begin <= 1'b0;
        e_end   <= 1'b0;
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_mode <= 1'b0;
            m_t    <= 0;
            m_lfsr <= SEED;
            e_data <= '0;
            e_idx  <= '0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
        end else if (hold) begin
            m_t <= m_t;
        end else if (!m_run) begin
            if (start) begin
                m_run  <= 1'b1;
                m_mode <= mode_full;
                m_t    <= 0;
                e_idx  <= '0;
                e_busy <= 1'b1;
                e_done <= 1'b0;
                if (mode_full) begin
                    e_data <= '0;
                end else begin
                    e_data <= IN_SIZE'(lstep(m_lfsr));
                    m_lfsr <= lstep(m_lfsr);
                end
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == TOTAL) begin
                m_run  <= 1'b0;
                e_busy <= 1'b0;
                e_done <= 1'b1;
                e_end  <= 1'b1;
                e_idx  <= e_idx + 1'b1;
            end else if ((m_t + 1) % (2 * PC) == PC) begin
                e_begin <= 1'b1;
                e_data  <= m_mode ? full_val((m_t + 1) / (2 * PC), 1'b1) : IN_SIZE'(lstep(m_lfsr));
                if (!m_mode) m_lfsr <= lstep(m_lfsr);
            end else if ((m_t + 1) % (2 * PC) == 0) begin
                e_end  <= 1'b1;
                e_idx  <= e_idx + 1'b1;
                e_data <= m_mode ? full_val((m_t + 1) / (2 * PC), 1'b0) : IN_SIZE'(lstep(m_lfsr));
                if (!m_mode) m_lfsr <= lstep(m_lfsr);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_data", 32'(in_data), 32'(e_data));
            check("sim_begin", 32'(sim_begin), 32'(e_begin));
            check("sim_end", 32'(sim_end), 32'(e_end));
            check("sim_idx", 32'(sim_idx), 32'(e_idx));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [IN_SIZE-1:0] cur[TOTAL];
    logic [IN_SIZE-1:0] ref_full[TOTAL];
    logic [IN_SIZE-1:0] ref_rnd[TOTAL];
    int nb, ne, fb, fe;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int ndiff(input logic [IN_SIZE-1:0] a[TOTAL], input logic [IN_SIZE-1:0] b[TOTAL]);
        int n;
        n = 0;
        for (int k = 0; k < TOTAL; k++) if (a[k] !== b[k]) n++;
        return n;
    endfunction

    // Start a run and record in_data for each of its TOTAL cycles; poke pulses start mid-run.
    task automatic run_rec(input bit m, input bit poke);
        start     = 1'b1;
        mode_full = m;
        tick();
        start = 1'b0;
        nb = 0; ne = 0; fb = -1; fe = -1;
        for (int t = 0; t < TOTAL; t++) begin
            cur[t] = in_data;
            if (sim_begin) begin nb++; if (fb < 0) fb = t; end
            if (sim_end)   begin ne++; if (fe < 0) fe = t; end
            if (poke && (t == 10 || t == 51)) begin
                start     = 1'b1;
                mode_full = !m;
            end
            tick();
            start     = 1'b0;
            mode_full = m;
        end
        check("run_end_pulse", 32'(sim_end), 32'd1);
        check("run_done", 32'(done), 32'd1);
        check("run_final_idx", 32'(sim_idx), 32'd9);   // 25 pairs mod 16
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; mode_full = 1'b0; hold = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        check("rst_in_data", 32'(in_data), 32'd0);
        check("rst_idx", 32'(sim_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Exhaustive run with truncation of index 4 to 0.
        run_rec(1'b1, 1'b0);
        ref_full = cur;
        check("full_t0", 32'(cur[0]), 32'd0);
        check("full_t6_j1", 32'(cur[6]), 32'd1);
        check("full_t14_j3", 32'(cur[14]), 32'd3);
        check("full_t18_j4_trunc", 32'(cur[18]), 32'd0);
        check("full_t20_i1", 32'(cur[20]), 32'd1);
        check("full_t54_pair13", 32'(cur[54]), 32'd3);
        check("full_t64_pair16", 32'(cur[64]), 32'd3);
        check("full_t84_pair21_trunc", 32'(cur[84]), 32'd0);
        check("full_t86_pair21", 32'(cur[86]), 32'd1);
        check("full_begin_count", nb, 25);
        check("full_end_count_in_run", ne, 24);
        check("full_first_begin", fb, 2);
        check("full_first_end", fe, 4);

        // Restart from DONE with start pulses while busy: stream must be unchanged.
        run_rec(1'b1, 1'b1);
        check("busy_start_ignored", ndiff(cur, ref_full), 0);

        // Synchronous reset in the middle of pair 3.
        start = 1'b1; mode_full = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        check("mid_idx_pair3", 32'(sim_idx), 32'd3);
        check("mid_busy", 32'(busy), 32'd1);
        do_reset();
        check("midrst_in_data", 32'(in_data), 32'd0);
        check("midrst_idx", 32'(sim_idx), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        run_rec(1'b1, 1'b0);
        check("after_rst_stream", ndiff(cur, ref_full), 0);

        // Hold for 3 edges at the start of the first SECOND phase.
        start = 1'b1; mode_full = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("hold_pre_begin", 32'(sim_begin), 32'd1);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_frozen_data", 32'(in_data), 32'd0);
            check("hold_frozen_idx", 32'(sim_idx), 32'd0);
        end
        hold = 1'b0;
        n = 0;
        while (!sim_end && n < 10) begin tick(); n++; end
        check("hold_end_edges_after_start", 5 + n, 7);
        check("hold_idx_after_end", 32'(sim_idx), 32'd1);
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("hold_run_done", 32'(done), 32'd1);

        // Random mode: reproducible after reset, continues without reseed otherwise.
        do_reset();
        run_rec(1'b0, 1'b0);
        ref_rnd = cur;
        check("rnd_t0", 32'(cur[0]), 32'd0);
        check("rnd_t2", 32'(cur[2]), 32'd2);
        check("rnd_t4", 32'(cur[4]), 32'd1);
        check("rnd_t6", 32'(cur[6]), 32'd1);
        check("rnd_t8", 32'(cur[8]), 32'd1);
        do_reset();
        run_rec(1'b0, 1'b0);
        check("rnd_repeat_after_reset", ndiff(cur, ref_rnd), 0);
        run_rec(1'b0, 1'b0);
        check("rnd_continue_differs", 32'(ndiff(cur, ref_rnd) > 0), 32'd1);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
